// File: rtl/rms_denorm_module_036.sv
// RMSNorm inverse stage: y = x_norm * rms, Q16.16 stream, 2-stage multiply pipeline.
// Optional RMS_DENORM_SAT_EN: saturate overflowing results instead of wrapping.
module rms_denorm_module_036 #(
   parameter int VEC_LEN   = 16,
   parameter int FRAC_BITS = 16,
   parameter int CNT_W     = $clog2(VEC_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             scale_valid,
   output logic             scale_ready,
   input  logic [31:0]      scale_data,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [31:0]      input_data,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [31:0]      output_data,
   output logic             last_out,
   output logic             busy,
   output logic [CNT_W-1:0] elem_count,
   output logic             ovf_flag
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic signed [65:0] RND = 66'sd1 <<< (FRAC_BITS - 1);

   state_t             state;
   logic [31:0]        scale_reg;
   logic               gen;
   logic               s1_valid;
   logic               s1_last;
   logic               s1_gen;
   logic signed [64:0] s1_prod;

   logic               stall;
   logic               in_hs;
   logic               scale_hs;
   logic               last_hs;
   logic signed [64:0] a_ext;
   logic signed [64:0] b_ext;
   logic signed [64:0] prod;
   logic signed [65:0] sum;
   logic signed [65:0] rnd_r;
   logic               r_ovf;
   logic [31:0]        r_data;

   assign stall    = valid_out && !ready_out;
   assign ready_in = (state == RUN) && !stall;
   assign in_hs    = valid_in && ready_in;
   assign scale_hs = scale_valid && scale_ready;
   assign last_hs  = in_hs && (elem_count == CNT_W'(VEC_LEN - 1));
   assign busy     = (state == RUN) || s1_valid || valid_out;

   assign a_ext = {{33{input_data[31]}}, input_data};
   assign b_ext = {33'd0, scale_reg};
   assign prod  = a_ext * b_ext;
   assign sum   = {s1_prod[64], s1_prod} + RND;
   assign rnd_r = sum >>> FRAC_BITS;
   assign r_ovf = (rnd_r[65:31] != {35{rnd_r[31]}});

`ifdef RMS_DENORM_SAT_EN
   assign r_data = !r_ovf   ? rnd_r[31:0] :
                   rnd_r[65] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
   assign r_data = rnd_r[31:0];
`endif

   // gen tags elements so a draining old vector cannot set the new flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         scale_ready <= 1'b1;
         scale_reg   <= '0;
         elem_count  <= '0;
         gen         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (scale_hs) begin
                  scale_reg   <= scale_data;
                  elem_count  <= '0;
                  gen         <= ~gen;
                  scale_ready <= 1'b0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (in_hs) begin
                  elem_count <= elem_count + CNT_W'(1);
                  if (last_hs) begin
                     scale_ready <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_last     <= 1'b0;
         s1_gen      <= 1'b0;
         s1_prod     <= '0;
         valid_out   <= 1'b0;
         last_out    <= 1'b0;
         output_data <= '0;
      end else if (!stall) begin
         s1_valid  <= in_hs;
         s1_last   <= last_hs;
         s1_gen    <= gen;
         if (in_hs)
            s1_prod <= prod;
         valid_out <= s1_valid;
         last_out  <= s1_valid && s1_last;
         if (s1_valid)
            output_data <= r_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_flag <= 1'b0;
      else if (scale_hs)
         ovf_flag <= 1'b0;
      else if (!stall && s1_valid && r_ovf && (s1_gen == gen))
         ovf_flag <= 1'b1;
   end

endmodule
